// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI bus between flash, DAC and pre-amp engines.
// Sequences chip-select setup/hold gaps, muxes the owner onto the pins and reclaims hung owners.
module spi_bus_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic       CCLK,
  input  logic       reset_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  input  logic [2:0] m_sclk,
  input  logic [2:0] m_mosi,
  output logic       m_miso,
  output logic       SPICLK,
  output logic       SPIMOSI,
  input  logic       SPIMISO,
  output logic       SPISF,
  output logic       DACCS,
  output logic       AMPCS,
  output logic       SFCE,
  output logic       FPGAIB,
  output logic       ADCON,
  output logic       timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, OWN, HOLDOFF} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      owner_reg, owner_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [2:0]      blocked_reg, blocked_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [TW-1:0]   gcnt_reg, gcnt_next;
  logic [2:0]      gnt_reg, gnt_next;
  logic [2:0]      cs_n_reg, cs_n_next;
  logic            timeout_err_reg, timeout_err_next;

  logic [2:0]      eligible;
  logic            win_valid;
  logic [1:0]      win_idx;

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // A master revoked by timeout stays ineligible until it lets go of req.
  assign eligible = req & ~blocked_reg;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (eligible[rr_idx(ptr_reg, 2'(k))]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx(ptr_reg, 2'(k));
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    ptr_next         = ptr_reg;
    blocked_next     = blocked_reg & req;
    cnt_next         = cnt_reg;
    gcnt_next        = gcnt_reg;
    gnt_next         = gnt_reg;
    cs_n_next        = cs_n_reg;
    timeout_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          owner_next = win_idx;
          cs_n_next  = ~(3'b001 << win_idx);
          cnt_next   = 4'd0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (!req[owner_reg]) begin
          cs_n_next  = 3'b111;
          ptr_next   = rr_idx(owner_reg, 2'd1);
          cnt_next   = 4'd0;
          state_next = HOLDOFF;
        end else if (cnt_reg == 4'(CS_SETUP - 1)) begin
          gnt_next   = 3'b001 << owner_reg;
          gcnt_next  = '0;
          state_next = OWN;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      OWN: begin
        if (!req[owner_reg] || gcnt_reg == TW'(TIMEOUT - 1)) begin
          gnt_next   = 3'b000;
          cs_n_next  = 3'b111;
          ptr_next   = rr_idx(owner_reg, 2'd1);
          cnt_next   = 4'd0;
          state_next = HOLDOFF;
          if (req[owner_reg]) begin
            timeout_err_next        = 1'b1;
            blocked_next[owner_reg] = 1'b1;
          end
        end else begin
          gcnt_next = gcnt_reg + 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt_reg == 4'(CS_HOLD - 1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      owner_reg       <= 2'd0;
      ptr_reg         <= 2'd0;
      blocked_reg     <= 3'b000;
      cnt_reg         <= 4'd0;
      gcnt_reg        <= '0;
      gnt_reg         <= 3'b000;
      cs_n_reg        <= 3'b111;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      ptr_reg         <= ptr_next;
      blocked_reg     <= blocked_next;
      cnt_reg         <= cnt_next;
      gcnt_reg        <= gcnt_next;
      gnt_reg         <= gnt_next;
      cs_n_reg        <= cs_n_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Mux is steered by the latched owner, so req activity cannot glitch the pins.
  assign SPICLK      = (state_reg == OWN) ? m_sclk[owner_reg] : 1'b0;
  assign SPIMOSI     = (state_reg == OWN) ? m_mosi[owner_reg] : 1'b0;
  assign m_miso      = SPIMISO;
  assign gnt         = gnt_reg;
  assign SPISF       = cs_n_reg[0];
  assign DACCS       = cs_n_reg[1];
  assign AMPCS       = cs_n_reg[2];
  assign timeout_err = timeout_err_reg;
  assign SFCE        = 1'b1;
  assign FPGAIB      = 1'b1;
  assign ADCON       = 1'b0;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed scenarios plus randomized masters,
// compared every cycle against an event-timeline model of the arbitration rules.
module tb_spi_bus_arbiter;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 4;
  localparam int TIMEOUT  = 32;

  logic       CCLK = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] m_sclk = 3'b000;
  logic [2:0] m_mosi = 3'b000;
  logic       SPIMISO = 1'b0;
  logic [2:0] gnt;
  logic       m_miso, SPICLK, SPIMOSI, SPISF, DACCS, AMPCS, SFCE, FPGAIB, ADCON, timeout_err;

  spi_bus_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .CCLK(CCLK), .reset_n(reset_n), .req(req), .gnt(gnt), .m_sclk(m_sclk), .m_mosi(m_mosi),
    .m_miso(m_miso), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI), .SPIMISO(SPIMISO), .SPISF(SPISF),
    .DACCS(DACCS), .AMPCS(AMPCS), .SFCE(SFCE), .FPGAIB(FPGAIB), .ADCON(ADCON),
    .timeout_err(timeout_err)
  );

  always #5 CCLK = ~CCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Timeline model: who owns the bus, when its CS fell, when its grant began,
  // and the first edge at which a new arbitration is allowed.
  int       m_owner = -1;
  int       m_ptr = 0;
  int       m_free_at = 0;
  int       m_cs_edge = 0;
  int       m_gnt_edge = 0;
  int       edge_n = 0;
  bit       m_granted = 0;
  bit       m_terr = 0;
  bit [2:0] m_blk = 3'b000;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_free_at = 0; m_granted = 0; m_terr = 0; m_blk = 3'b000;
  endtask

  task automatic model_release(input bit by_timeout);
    m_ptr = (m_owner + 1) % 3;
    if (by_timeout) begin
      m_blk[m_owner] = 1'b1;
      m_terr = 1'b1;
    end
    m_free_at = edge_n + CS_HOLD + 1;
    m_owner = -1;
    m_granted = 0;
  endtask

  task automatic model_step();
    m_terr = 0;
    for (int i = 0; i < 3; i++) if (!req[i]) m_blk[i] = 1'b0;
    if (m_owner < 0) begin
      if (edge_n >= m_free_at) begin
        for (int k = 0; k < 3; k++) begin
          int c;
          c = (m_ptr + k) % 3;
          if (req[c] && !m_blk[c]) begin
            m_owner = c;
            m_cs_edge = edge_n;
            break;
          end
        end
      end
    end else if (!req[m_owner]) begin
      model_release(1'b0);
    end else if (!m_granted) begin
      if (edge_n - m_cs_edge == CS_SETUP) begin
        m_granted = 1;
        m_gnt_edge = edge_n;
      end
    end else if (edge_n - m_gnt_edge == TIMEOUT) begin
      model_release(1'b1);
    end
    edge_n++;
  endtask

  task automatic compare_all();
    logic [2:0] e_gnt, e_cs;
    logic       e_clk, e_mosi;
    e_gnt  = m_granted ? 3'(3'b001 << m_owner) : 3'b000;
    e_cs   = (m_owner >= 0) ? ~3'(3'b001 << m_owner) : 3'b111;
    e_clk  = m_granted ? m_sclk[m_owner] : 1'b0;
    e_mosi = m_granted ? m_mosi[m_owner] : 1'b0;
    check_value("gnt", gnt, e_gnt);
    check_value("cs_amp_dac_sf", {AMPCS, DACCS, SPISF}, e_cs);
    check_value("timeout_err", timeout_err, m_terr);
    check_value("spiclk", SPICLK, e_clk);
    check_value("spimosi", SPIMOSI, e_mosi);
    check_value("m_miso", m_miso, SPIMISO);
    check_value("sfce_fpgaib_adcon", {SFCE, FPGAIB, ADCON}, 3'b110);
  endtask

  task automatic step();
    @(posedge CCLK);
    model_step();
    @(negedge CCLK);
    compare_all();
    m_sclk  = 3'($urandom_range(0, 7));
    m_mosi  = 3'($urandom_range(0, 7));
    SPIMISO = 1'($urandom_range(0, 1));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset applied between edges; outputs must clear before any clock.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check_value("rst_gnt", gnt, 3'b000);
    check_value("rst_cs", {AMPCS, DACCS, SPISF}, 3'b111);
    check_value("rst_spiclk", SPICLK, 1'b0);
    check_value("rst_spimosi", SPIMOSI, 1'b0);
    check_value("rst_terr", timeout_err, 1'b0);
    check_value("rst_consts", {SFCE, FPGAIB, ADCON}, 3'b110);
    @(negedge CCLK);
    check_value("rst_hold_consts", {SFCE, FPGAIB, ADCON}, 3'b110);
    @(negedge CCLK);
    reset_n = 1'b1;
    model_reset();
  endtask

  int hold[3];
  int wait_c[3];

  task automatic run_random(input int n);
    for (int c = 0; c < n; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            req[i] = 1'b1;
            hold[i] = ($urandom_range(0, 5) == 0) ? 40 : int'($urandom_range(1, 10));
            wait_c[i] = 0;
          end
        end else if (gnt[i]) begin
          if (hold[i] <= 1) req[i] = 1'b0;
          else hold[i]--;
        end else begin
          wait_c[i]++;
          if (wait_c[i] > 50 || $urandom_range(0, 60) == 0) req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int lat_cs, lat_gnt, high_run, dac_len, terr_cnt, amp_len;
    bit seen_low, dac_done, regrant, owned, seen_bad, got;
    logic [2:0] order[$];
    logic [2:0] last_gnt, next_gnt;

    do_reset();

    // Single flash request: CS one cycle after req, grant three cycles after req.
    req = 3'b001;
    lat_cs = 0; lat_gnt = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (SPISF == 1'b0 && lat_cs == 0) lat_cs = c;
      if (gnt == 3'b001 && lat_gnt == 0) lat_gnt = c;
    end
    check_value("flash_cs_latency", lat_cs, 1);
    check_value("flash_gnt_latency", lat_gnt, 3);
    req = 3'b000;
    steps(8);

    // Simultaneous requests from reset resolve in round-robin order with CS gaps.
    do_reset();
    req = 3'b111;
    order.delete();
    last_gnt = 3'b000; high_run = 0; seen_low = 0;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (gnt != 3'b000 && gnt != last_gnt) order.push_back(gnt);
      last_gnt = gnt;
      for (int i = 0; i < 3; i++) if (gnt[i]) begin
        hold[i]++;
        if (hold[i] == 3) req[i] = 1'b0;
      end
      if ({AMPCS, DACCS, SPISF} == 3'b111) high_run++;
      else begin
        if (seen_low && high_run > 0) check_value("rr_cs_gap_ge5", 32'(high_run >= CS_HOLD + 1), 1);
        high_run = 0;
        seen_low = 1;
      end
    end
    check_value("rr_grant_count", order.size(), 3);
    if (order.size() == 3) begin
      check_value("rr_first", order[0], 3'b001);
      check_value("rr_second", order[1], 3'b010);
      check_value("rr_third", order[2], 3'b100);
    end

    // Flash holds the bus; DAC request waits for release plus holdoff.
    req = 3'b001;
    steps(6);
    req = 3'b011;
    seen_bad = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (gnt[1]) seen_bad = 1;
    end
    check_value("no_preempt_dac", seen_bad, 1'b0);
    req = 3'b010;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (gnt == 3'b010) got = 1;
    end
    check_value("dac_after_flash", got, 1'b1);
    req = 3'b000;
    steps(8);

    // DAC holds forever: exactly TIMEOUT grant cycles, one error pulse, amp next, no regrant.
    req = 3'b010;
    dac_len = 0; terr_cnt = 0; amp_len = 0; dac_done = 0; regrant = 0; next_gnt = 3'b000;
    for (int c = 0; c < 150; c++) begin
      step();
      if (c == 5) req[2] = 1'b1;
      if (timeout_err) terr_cnt++;
      if (gnt[1] && !dac_done) dac_len++;
      if (gnt[1] && dac_done) regrant = 1;
      if (dac_len > 0 && !gnt[1]) dac_done = 1;
      if (dac_done && gnt != 3'b000 && next_gnt == 3'b000) next_gnt = gnt;
      if (gnt[2]) begin
        amp_len++;
        if (amp_len == 4) req[2] = 1'b0;
      end
    end
    check_value("timeout_gnt_len", dac_len, TIMEOUT);
    check_value("timeout_err_pulses", terr_cnt, 1);
    check_value("timeout_next_owner", next_gnt, 3'b100);
    check_value("timeout_no_regrant", regrant, 1'b0);
    req[1] = 1'b0;
    steps(3);
    req[1] = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (gnt == 3'b010) got = 1;
    end
    check_value("dac_regrant_after_drop", got, 1'b1);
    req = 3'b000;
    steps(8);

    // Asynchronous reset while the amp owns the bus.
    req = 3'b100;
    owned = 0;
    for (int c = 0; c < 20 && !owned; c++) begin
      step();
      if (gnt == 3'b100) owned = 1;
    end
    check_value("amp_owned_before_reset", owned, 1'b1);
    steps(2);
    do_reset();
    steps(6);
    req = 3'b000;
    steps(8);

    // Flash drops req during setup: no grant, full holdoff before DAC's CS falls.
    req = 3'b001;
    step();
    req = 3'b010;
    seen_bad = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (gnt[0]) seen_bad = 1;
    end
    check_value("setup_drop_no_gnt", seen_bad, 1'b0);
    req = 3'b000;
    steps(10);

    for (int i = 0; i < 3; i++) begin
      hold[i] = 0;
      wait_c[i] = 0;
    end
    run_random(2000);
    req = 3'b000;
    steps(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
